// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
package fwd_hazard_pkg;

  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10,
    FWD_RETIRE = 2'b11
  } fwd_sel_e;

  typedef enum logic [0:0] {
    HZ_IDLE  = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: picks the youngest writing stage for one ID operand and
// reports raw EX/MEM destination hits for load-use detection in the parent.
module fwd_src_cmp
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [FWD_SEL_W-1:0]  sel_o,
  output logic                  ex_hit_o,
  output logic                  mem_hit_o
);

  logic active;
  logic wb_hit;

  always_comb begin
    active    = used_i && (rs_i != '0);
    ex_hit_o  = active && ex_regwrite_i  && (ex_rd_i  == rs_i);
    mem_hit_o = active && mem_regwrite_i && (mem_rd_i == rs_i);
    wb_hit    = active && wb_regwrite_i  && (wb_rd_i  == rs_i);

    // Youngest producer wins.
    if (ex_hit_o) begin
      sel_o = FWD_EX_MEM;
    end else if (mem_hit_o) begin
      sel_o = FWD_MEM_WB;
    end else if (wb_hit) begin
      sel_o = FWD_RETIRE;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage RV32 pipeline.
// Optional perf counters are built only when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
  import fwd_hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]            id_rs_used_i,
  input  logic [REG_ADDR_W-1:0]         ex_rd_i,
  input  logic                          ex_regwrite_i,
  input  logic                          ex_memread_i,
  input  logic [REG_ADDR_W-1:0]         mem_rd_i,
  input  logic                          mem_regwrite_i,
  input  logic                          mem_memread_i,
  input  logic [REG_ADDR_W-1:0]         wb_rd_i,
  input  logic                          wb_regwrite_i,
  input  logic                          flush_i,
  output logic [NUM_SRC*2-1:0]          fwd_sel_o,
  output logic                          stall_o,
  output logic                          bubble_o,
  output logic [31:0]                   perf_stall_cnt_o,
  output logic [31:0]                   perf_lu_cnt_o
);

  logic [NUM_SRC*FWD_SEL_W-1:0] sel_calc;
  logic [NUM_SRC-1:0]           ex_hit;
  logic [NUM_SRC-1:0]           mem_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_cmp (
      .rs_i          (id_rs_i[i*REG_ADDR_W +: REG_ADDR_W]),
      .used_i        (id_rs_used_i[i]),
      .ex_rd_i       (ex_rd_i),
      .ex_regwrite_i (ex_regwrite_i),
      .mem_rd_i      (mem_rd_i),
      .mem_regwrite_i(mem_regwrite_i),
      .wb_rd_i       (wb_rd_i),
      .wb_regwrite_i (wb_regwrite_i),
      .sel_o         (sel_calc[i*FWD_SEL_W +: FWD_SEL_W]),
      .ex_hit_o      (ex_hit[i]),
      .mem_hit_o     (mem_hit[i])
    );
  end

  logic             ex_load_hz;
  logic             mem_load_hz;
  logic [CNT_W-1:0] need;

  always_comb begin
    ex_load_hz  = ex_memread_i && (|ex_hit);
    // A load one stage further along only still blocks when data takes two cycles.
    mem_load_hz = (LOAD_LAT == 2) && mem_memread_i && (|mem_hit);
    if (ex_load_hz) begin
      need = CNT_W'(LOAD_LAT);
    end else if (mem_load_hz) begin
      need = CNT_W'(1);
    end else begin
      need = '0;
    end
  end

  hz_state_e                    state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic                         stall, bubble;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd_sel_d = sel_calc;
    stall     = 1'b0;
    bubble    = 1'b0;
    if (flush_i) begin
      bubble    = 1'b1;
      fwd_sel_d = '0;
      state_d   = HZ_IDLE;
      cnt_d     = '0;
    end else begin
      case (state_q)
        HZ_IDLE: begin
          if (need != '0) begin
            stall     = 1'b1;
            bubble    = 1'b1;
            fwd_sel_d = '0;
            if (need > CNT_W'(1)) begin
              cnt_d   = need - CNT_W'(1);
              state_d = HZ_STALL;
            end
          end
        end
        HZ_STALL: begin
          stall     = 1'b1;
          bubble    = 1'b1;
          fwd_sel_d = '0;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = HZ_IDLE;
          end
        end
        default: begin
          state_d = HZ_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HZ_IDLE;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel_o = fwd_sel_q;
  // Hazard logic is combinational on live inputs; mask it while held in reset.
  assign stall_o   = stall & rst_n;
  assign bubble_o  = bubble & rst_n;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_lu_q, perf_lu_d;
  logic        lu_evt;

  always_comb begin
    lu_evt       = !flush_i && (state_q == HZ_IDLE) && (need != '0);
    perf_stall_d = perf_stall_q;
    perf_lu_d    = perf_lu_q;
    if (stall && !flush_i && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (lu_evt && (perf_lu_q != '1)) begin
      perf_lu_d = perf_lu_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_lu_cnt_o    = perf_lu_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_lu_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (LOAD_LAT=1/NUM_SRC=2 and LOAD_LAT=2/NUM_SRC=3)
// share stimulus and are checked every cycle against a stall-budget model.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] id_rs;
  logic [2:0]  id_used;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, flush;

  logic [3:0]  fwd_sel_1;
  logic [5:0]  fwd_sel_2;
  logic        stall_1, bubble_1, stall_2, bubble_2;
  logic [31:0] pst_1, plu_1, pst_2, plu_2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.NUM_SRC(2), .REG_ADDR_W(5), .LOAD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs[9:0]), .id_rs_used_i(id_used[1:0]),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .flush_i(flush),
    .fwd_sel_o(fwd_sel_1), .stall_o(stall_1), .bubble_o(bubble_1),
    .perf_stall_cnt_o(pst_1), .perf_lu_cnt_o(plu_1)
  );

  fwd_hazard_ctrl #(.NUM_SRC(3), .REG_ADDR_W(5), .LOAD_LAT(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rs_used_i(id_used),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite), .flush_i(flush),
    .fwd_sel_o(fwd_sel_2), .stall_o(stall_2), .bubble_o(bubble_2),
    .perf_stall_cnt_o(pst_2), .perf_lu_cnt_o(plu_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: "remain" is the number of forced stall cycles still owed after this one.
  function automatic void model_eval(input int lat, input int nsrc, input int remain,
                                     output bit stall, output bit bubble,
                                     output logic [5:0] nsel, output int nrem, output bit lu);
    int          need;
    logic [5:0]  calc;
    logic [4:0]  rs;
    need = 0;
    calc = '0;
    for (int i = 0; i < nsrc; i++) begin
      rs = id_rs[i*5 +: 5];
      if (id_used[i] && rs != 5'd0) begin
        if (ex_regwrite && ex_rd == rs)        calc[2*i +: 2] = 2'b10;
        else if (mem_regwrite && mem_rd == rs) calc[2*i +: 2] = 2'b01;
        else if (wb_regwrite && wb_rd == rs)   calc[2*i +: 2] = 2'b11;
        if (ex_memread && ex_regwrite && ex_rd == rs && need < lat) need = lat;
        if (lat == 2 && mem_memread && mem_regwrite && mem_rd == rs && need < 1) need = 1;
      end
    end
    stall = 1'b0; bubble = 1'b0; lu = 1'b0;
    if (flush) begin
      bubble = 1'b1; nsel = '0; nrem = 0;
    end else if (remain > 0) begin
      stall = 1'b1; bubble = 1'b1; nsel = '0; nrem = remain - 1;
    end else if (need > 0) begin
      stall = 1'b1; bubble = 1'b1; nsel = '0; nrem = need - 1; lu = 1'b1;
    end else begin
      nsel = calc; nrem = 0;
    end
  endfunction

  int          m_remain [2];
  logic [5:0]  m_sel    [2];
  logic [31:0] m_pst    [2];
  logic [31:0] m_plu    [2];

  always @(posedge clk or negedge rst_n) begin : model
    bit s, b, lu;
    logic [5:0] ns;
    int nr;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_remain[k] <= 0; m_sel[k] <= '0; m_pst[k] <= '0; m_plu[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        model_eval(k + 1, k + 2, m_remain[k], s, b, ns, nr, lu);
        m_remain[k] <= nr;
        m_sel[k]    <= ns;
        if (s && m_pst[k] != 32'hFFFF_FFFF)  m_pst[k] <= m_pst[k] + 32'd1;
        if (lu && m_plu[k] != 32'hFFFF_FFFF) m_plu[k] <= m_plu[k] + 32'd1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit s, b, lu;
    logic [5:0] ns;
    int nr;
    if (!rst_n) begin
      chk("rst_stall_l2", 32'(stall_2), 32'd0);
      chk("rst_bubble_l2", 32'(bubble_2), 32'd0);
      chk("rst_sel_l2", 32'(fwd_sel_2), 32'd0);
      chk("rst_sel_l1", 32'(fwd_sel_1), 32'd0);
    end else begin
      model_eval(1, 2, m_remain[0], s, b, ns, nr, lu);
      chk("stall_l1", 32'(stall_1), 32'(s));
      chk("bubble_l1", 32'(bubble_1), 32'(b));
      chk("sel_l1", 32'(fwd_sel_1), 32'(m_sel[0][3:0]));
      model_eval(2, 3, m_remain[1], s, b, ns, nr, lu);
      chk("stall_l2", 32'(stall_2), 32'(s));
      chk("bubble_l2", 32'(bubble_2), 32'(b));
      chk("sel_l2", 32'(fwd_sel_2), 32'(m_sel[1]));
`ifdef FWD_HAZARD_PERF_EN
      chk("pst_l1", pst_1, m_pst[0]);
      chk("plu_l1", plu_1, m_plu[0]);
      chk("pst_l2", pst_2, m_pst[1]);
      chk("plu_l2", plu_2, m_plu[1]);
`else
      chk("pst_l1", pst_1, 32'd0);
      chk("plu_l2", plu_2, 32'd0);
`endif
    end
  end

  task automatic idle_in();
    id_rs = '0; id_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0; wb_regwrite = 0;
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load_rs1_x3();
    idle_in();
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
    id_rs[9:5] = 5'd3; id_used = 3'b010;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_load_rs1_x3();
    #2;
    chk("lit_rst_stall_gated", 32'(stall_2), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b1;
    tick();

    // EX ALU producer
    ex_regwrite = 1; ex_rd = 5'd5; id_rs[4:0] = 5'd5; id_used = 3'b001;
    #1 chk("lit_alu_nostall", 32'(stall_1), 32'd0);
    tick();
    chk("lit_alu_sel_l1", 32'(fwd_sel_1[1:0]), 32'd2);
    chk("lit_alu_sel_l2", 32'(fwd_sel_2[1:0]), 32'd2);
    // MEM and WB producers
    idle_in(); mem_regwrite = 1; mem_rd = 5'd7; id_rs[4:0] = 5'd7; id_used = 3'b001;
    tick();
    chk("lit_mem_sel", 32'(fwd_sel_1[1:0]), 32'd1);
    idle_in(); wb_regwrite = 1; wb_rd = 5'd7; id_rs[4:0] = 5'd7; id_used = 3'b001;
    tick();
    chk("lit_wb_sel", 32'(fwd_sel_1[1:0]), 32'd3);
    // x0 never forwards
    idle_in(); ex_regwrite = 1; mem_regwrite = 1; wb_regwrite = 1; id_used = 3'b111;
    tick();
    chk("lit_x0_sel_l1", 32'(fwd_sel_1), 32'd0);
    chk("lit_x0_sel_l2", 32'(fwd_sel_2), 32'd0);

    // Load-use, load walking EX -> MEM -> WB
    ex_load_rs1_x3();
    #1;
    chk("lit_lu_stall_l1", 32'(stall_1), 32'd1);
    chk("lit_lu_bubble_l1", 32'(bubble_1), 32'd1);
    chk("lit_lu_stall_l2", 32'(stall_2), 32'd1);
    tick();
    chk("lit_lu_bubble_sel_l1", 32'(fwd_sel_1), 32'd0);
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd3;
    #1;
    chk("lit_lu_exit_l1", 32'(stall_1), 32'd0);
    chk("lit_lu_stall2_l2", 32'(stall_2), 32'd1);
    tick();
    chk("lit_lu_after_l1", 32'(fwd_sel_1[3:2]), 32'd1);
    chk("lit_lu_bubble_sel_l2", 32'(fwd_sel_2), 32'd0);
    mem_regwrite = 0; mem_memread = 0; wb_regwrite = 1; wb_rd = 5'd3;
    #1 chk("lit_lu_exit_l2", 32'(stall_2), 32'd0);
    tick();
    chk("lit_lu_after_l2", 32'(fwd_sel_2[3:2]), 32'd3);

    // Load already in MEM: one bubble only at LOAD_LAT=2
    idle_in(); mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd3;
    id_rs[9:5] = 5'd3; id_used = 3'b010;
    #1;
    chk("lit_memld_stall_l2", 32'(stall_2), 32'd1);
    chk("lit_memld_nostall_l1", 32'(stall_1), 32'd0);
    tick();
    chk("lit_memld_sel_l1", 32'(fwd_sel_1[3:2]), 32'd1);
    idle_in(); wb_regwrite = 1; wb_rd = 5'd3; id_rs[9:5] = 5'd3; id_used = 3'b010;
    #1 chk("lit_memld_exit_l2", 32'(stall_2), 32'd0);
    tick();
    chk("lit_memld_after_l2", 32'(fwd_sel_2[3:2]), 32'd3);

    // Flush aborts a stall in progress
    ex_load_rs1_x3();
    tick();
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd3;
    flush = 1;
    #1;
    chk("lit_flush_stall_l2", 32'(stall_2), 32'd0);
    chk("lit_flush_bubble_l2", 32'(bubble_2), 32'd1);
    tick();
    chk("lit_flush_sel_l2", 32'(fwd_sel_2), 32'd0);
    idle_in(); ex_regwrite = 1; ex_rd = 5'd9; id_rs[4:0] = 5'd9; id_used = 3'b001;
    #1 chk("lit_flush_idle_l2", 32'(stall_2), 32'd0);
    tick();
    chk("lit_flush_after_l2", 32'(fwd_sel_2[1:0]), 32'd2);

    // Perf: three load-use events after a clean reset
    idle_in();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      ex_load_rs1_x3();
      tick();
      idle_in();
      tick();
      tick();
    end
`ifdef FWD_HAZARD_PERF_EN
    chk("lit_perf_lu_l2", plu_2, 32'd3);
    chk("lit_perf_st_l2", pst_2, 32'd6);
    chk("lit_perf_lu_l1", plu_1, 32'd3);
    chk("lit_perf_st_l1", pst_1, 32'd3);
`else
    chk("lit_perf_off_lu", plu_2, 32'd0);
    chk("lit_perf_off_st", pst_2, 32'd0);
`endif

    // Asynchronous reset in the middle of a stall
    ex_load_rs1_x3();
    tick();
    ex_load_rs1_x3();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_stall_l2", 32'(stall_2), 32'd0);
    chk("lit_arst_bubble_l2", 32'(bubble_2), 32'd0);
    chk("lit_arst_sel_l2", 32'(fwd_sel_2), 32'd0);
    chk("lit_arst_perf_l2", pst_2, 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    rst_n = 1'b1;

    // Random traffic over a small register window to force collisions
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 3; i++) id_rs[i*5 +: 5] = 5'($urandom_range(0, 3));
      id_used      = 3'($urandom_range(0, 7));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      mem_regwrite = ($urandom_range(0, 3) != 0);
      wb_regwrite  = ($urandom_range(0, 3) != 0);
      ex_memread   = ($urandom_range(0, 1) != 0);
      mem_memread  = ($urandom_range(0, 1) != 0);
      flush        = ($urandom_range(0, 15) == 0);
    end
    tick();
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
